// File: rtl/mips_isa_pkg.sv
// MIPS-I encoding constants, the op_sel mnemonic enumeration and word-building helpers
// shared by the instruction encoder and its field packer.
package mips_isa_pkg;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_ADDU  = 5'd1,
        OP_SUB   = 5'd2,
        OP_SUBU  = 5'd3,
        OP_AND   = 5'd4,
        OP_NOR   = 5'd5,
        OP_OR    = 5'd6,
        OP_XOR   = 5'd7,
        OP_SLT   = 5'd8,
        OP_SRL   = 5'd9,
        OP_SRLV  = 5'd10,
        OP_SRA   = 5'd11,
        OP_SRAV  = 5'd12,
        OP_SLL   = 5'd13,
        OP_SLLV  = 5'd14,
        OP_J     = 5'd15,
        OP_JAL   = 5'd16,
        OP_ADDI  = 5'd17,
        OP_ADDIU = 5'd18,
        OP_ANDI  = 5'd19,
        OP_ORI   = 5'd20,
        OP_XORI  = 5'd21,
        OP_BEQ   = 5'd22,
        OP_BNE   = 5'd23,
        OP_LW    = 5'd24,
        OP_SW    = 5'd25
    } op_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_TERM = 2'd2,
        ST_DONE = 2'd3
    } enc_state_e;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FUNC_SLL  = 6'h00;
    localparam logic [5:0] FUNC_SRL  = 6'h02;
    localparam logic [5:0] FUNC_SRA  = 6'h03;
    localparam logic [5:0] FUNC_SLLV = 6'h04;
    localparam logic [5:0] FUNC_SRLV = 6'h06;
    localparam logic [5:0] FUNC_SRAV = 6'h07;
    localparam logic [5:0] FUNC_ADD  = 6'h20;
    localparam logic [5:0] FUNC_ADDU = 6'h21;
    localparam logic [5:0] FUNC_SUB  = 6'h22;
    localparam logic [5:0] FUNC_SUBU = 6'h23;
    localparam logic [5:0] FUNC_AND  = 6'h24;
    localparam logic [5:0] FUNC_OR   = 6'h25;
    localparam logic [5:0] FUNC_XOR  = 6'h26;
    localparam logic [5:0] FUNC_NOR  = 6'h27;
    localparam logic [5:0] FUNC_SLT  = 6'h2A;

    localparam logic [31:0] TERM_WORD = 32'hFFFF_FFFF;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] func);
        return {OPC_RTYPE, rs, rt, rd, shamt, func};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_word(input logic [5:0] opc, input logic [25:0] target);
        return {opc, target};
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational MIPS-I word packer: maps an op_sel mnemonic plus operand fields to a
// 32-bit instruction word and flags op_sel values outside the mnemonic table.
module instr_field_pack
    import mips_isa_pkg::*;
(
    input  logic [4:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // Only the immediate shifts carry shamt; every other R-type encodes zero there.
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op_sel)
            OP_ADD:   word = r_word(rs, rt, rd, 5'd0, FUNC_ADD);
            OP_ADDU:  word = r_word(rs, rt, rd, 5'd0, FUNC_ADDU);
            OP_SUB:   word = r_word(rs, rt, rd, 5'd0, FUNC_SUB);
            OP_SUBU:  word = r_word(rs, rt, rd, 5'd0, FUNC_SUBU);
            OP_AND:   word = r_word(rs, rt, rd, 5'd0, FUNC_AND);
            OP_NOR:   word = r_word(rs, rt, rd, 5'd0, FUNC_NOR);
            OP_OR:    word = r_word(rs, rt, rd, 5'd0, FUNC_OR);
            OP_XOR:   word = r_word(rs, rt, rd, 5'd0, FUNC_XOR);
            OP_SLT:   word = r_word(rs, rt, rd, 5'd0, FUNC_SLT);
            OP_SRL:   word = r_word(rs, rt, rd, shamt, FUNC_SRL);
            OP_SRLV:  word = r_word(rs, rt, rd, 5'd0, FUNC_SRLV);
            OP_SRA:   word = r_word(rs, rt, rd, shamt, FUNC_SRA);
            OP_SRAV:  word = r_word(rs, rt, rd, 5'd0, FUNC_SRAV);
            OP_SLL:   word = r_word(rs, rt, rd, shamt, FUNC_SLL);
            OP_SLLV:  word = r_word(rs, rt, rd, 5'd0, FUNC_SLLV);
            OP_J:     word = j_word(OPC_J, target);
            OP_JAL:   word = j_word(OPC_JAL, target);
            OP_ADDI:  word = i_word(OPC_ADDI, rs, rt, imm);
            OP_ADDIU: word = i_word(OPC_ADDIU, rs, rt, imm);
            OP_ANDI:  word = i_word(OPC_ANDI, rs, rt, imm);
            OP_ORI:   word = i_word(OPC_ORI, rs, rt, imm);
            OP_XORI:  word = i_word(OPC_XORI, rs, rt, imm);
            OP_BEQ:   word = i_word(OPC_BEQ, rs, rt, imm);
            OP_BNE:   word = i_word(OPC_BNE, rs, rt, imm);
            OP_LW:    word = i_word(OPC_LW, rs, rt, imm);
            OP_SW:    word = i_word(OPC_SW, rs, rt, imm);
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts mnemonic requests, writes encoded words to instruction
// memory, and appends a terminator on finish. Optional INSTR_ENC_BRANCH_REL_EN makes
// beq/bne imm an absolute word address converted to a PC-relative offset.
module instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    input  logic              finish,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_INC   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_INC   = (ADDR_W + 1)'(1);

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       word_q, word_d;
    logic              err_q, err_d;

    logic [15:0]       imm_eff;
    logic [31:0]       packed_word;
    logic              illegal;
    logic              accept;

`ifdef INSTR_ENC_BRANCH_REL_EN
    // Offset is relative to the word after the branch, i.e. target - (pc + 1).
    always_comb begin
        imm_eff = imm;
        if (op_sel == OP_BEQ || op_sel == OP_BNE) begin
            imm_eff = imm - (16'(wr_ptr_q) + 16'd1);
        end
    end
`else
    assign imm_eff = imm;
`endif

    instr_field_pack u_pack (
        .op_sel  (op_sel),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .imm     (imm_eff),
        .target  (target),
        .word    (packed_word),
        .illegal (illegal)
    );

    // The last memory word stays free so a terminator always fits.
    assign in_ready = rst_n && (state_q == ST_IDLE) && (wr_ptr_q < LAST_ADDR);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        word_d   = word_q;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        word_d  = packed_word;
                        state_d = ST_EMIT;
                    end
                end else if (finish) begin
                    state_d = ST_TERM;
                end
            end
            ST_EMIT: begin
                wr_ptr_d = wr_ptr_q + PTR_INC;
                count_d  = count_q + CNT_INC;
                state_d  = ST_IDLE;
            end
            ST_TERM: begin
                count_d = count_q + CNT_INC;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (clear) begin
            state_d  = ST_IDLE;
            wr_ptr_d = '0;
            count_d  = '0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            count_q  <= '0;
            word_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            word_q   <= word_d;
            err_q    <= err_d;
        end
    end

    // The write strobe is gated by clear so an abandoned write never reaches memory.
    assign mem_we    = ((state_q == ST_EMIT) || (state_q == ST_TERM)) && !clear;
    assign mem_addr  = wr_ptr_q;
    assign mem_wdata = (state_q == ST_TERM) ? TERM_WORD : word_q;
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign count     = count_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, default 512: instruction-memory depth in words.
REQ-002 Parameter ADDR_W, default $clog2(DEPTH): word-address width.
REQ-003 Ports are listed as name, direction, width, meaning. The first two ports SHALL be: clk, in, 1, sole clock; rst_n, in, 1, asynchronous active-low reset.
REQ-004 clear, in, 1: synchronous restart of the encoder to IDLE with pointer 0.
REQ-005 in_valid, in, 1 and in_ready, out, 1: instruction request handshake.
REQ-006 op_sel, in, 5: mnemonic index 0-25, ordered add, addu, sub, subu, and, nor, or, xor, slt, srl, srlv, sra, srav, sll, sllv, j, jal, addi, addiu, andi, ori, xori, beq, bne, lw, sw.
REQ-007 Operand ports, all inputs: rs, rt, rd and shamt, 5 bits each; imm, 16 bits; target, 26 bits.
REQ-008 finish, in, 1: request that the terminator word be appended.
REQ-009 Memory write ports, all outputs: mem_we, 1 bit; mem_addr, ADDR_W bits; mem_wdata, 32 bits.
REQ-010 Status outputs:
- done, 1 bit: terminator written.
- err, 1 bit: one-cycle pulse for an illegal op_sel.
- count, ADDR_W+1 bits: words written, terminator included.

Function
REQ-011 The encoder SHALL have four states: IDLE, EMIT, TERM and DONE.
REQ-012 in_ready SHALL be 1 only in IDLE while wr_ptr < DEPTH-1; the last word is reserved for the terminator.
REQ-013 Accept: in IDLE, in_valid && in_ready registers the encoded word and moves to EMIT.
REQ-014 EMIT lasts one cycle:
- mem_we=1, mem_addr=wr_ptr, mem_wdata=the registered word.
- Then wr_ptr++, count++ and return to IDLE.
- Latency is accept edge plus one cycle; peak throughput is one word every 2 cycles.
REQ-015 R-type encoding: {6'b0, rs, rt, rd, shamt, func}. func values: add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A, sll 0x00, srl 0x02, sra 0x03, sllv 0x04, srlv 0x06, srav 0x07.
REQ-016 Immediate-shift inputs: shamt is used only by sll, srl and sra; the other R-types force shamt=0.
REQ-017 J-type encoding: {opcode, target}, with j=0x02 and jal=0x03.
REQ-018 I-type encoding: {opcode, rs, rt, imm}. Opcodes: addi 0x08, addiu 0x09, andi 0x0C, ori 0x0D, xori 0x0E, beq 0x04, bne 0x05, lw 0x23, sw 0x2B.
REQ-019 Illegal op_sel (26-31): the request is accepted, err=1 for one cycle, nothing is written, and the state stays IDLE.
REQ-020 finish in IDLE with no accept in the same cycle: move to TERM.
REQ-021 TERM: mem_we=1, mem_wdata=0xFFFFFFFF, mem_addr=wr_ptr, count++, then move to DONE.
REQ-022 If in_valid && in_ready and finish occur in the same cycle, the instruction wins; finish is honoured only if still asserted in a later IDLE cycle.
REQ-023 When full (wr_ptr==DEPTH-1), finish is still accepted, so the terminator lands at address DEPTH-1.
REQ-024 DONE is absorbing: done=1, in_ready=0 and mem_we=0 until clear or reset.
REQ-025 clear asserted in any state, including EMIT and TERM: the pending write is dropped and the next state is IDLE with wr_ptr=0, count=0, done=0.

Reset
REQ-026 rst_n low SHALL asynchronously force:
- State IDLE, wr_ptr=0, count=0.
- mem_we=0, mem_addr=0, mem_wdata=0.
- done=0, err=0.
REQ-027 Reset during EMIT or TERM SHALL deassert mem_we immediately, with no partial write.
REQ-028 in_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release.

Configuration
REQ-029 Macro INSTR_ENC_BRANCH_REL_EN.
- Defined: for beq/bne, imm is an absolute word address, and the encoded field is imm - (wr_ptr+1), truncated to 16 bits.
- Undefined: imm is used verbatim.

Structure
REQ-030 Package mips_isa_pkg SHALL hold:
- The opcode and func constants.
- The op_sel enumeration.
- TERM_WORD = 32'hFFFFFFFF.
REQ-031 The encoding is a combinational sub-module instr_field_pack (op_sel and fields in; word and illegal flag out); the FSM, pointer and handshake stay in instr_encoder.

Verification
REQ-032 Bench scenario, add: op=add, rs=1, rt=2, rd=3 -> the cycle after accept, mem_we=1, addr 0, data 0x00221820, count=1.
REQ-033 Bench scenario, lw and sll:
- lw, rt=8, rs=29, imm=4 -> 0x8FA80004.
- sll, rd=2, rt=4, shamt=3 -> 0x000410C0.
REQ-034 Bench scenario, j and illegal op_sel:
- j, target=0x10 -> 0x08000010.
- op_sel=30 -> err pulse, no write, count unchanged.
REQ-035 Bench scenario, full: with DEPTH=4, write 3 instructions, then in_ready=0; finish -> 0xFFFFFFFF at addr 3, done=1, count=4.
REQ-036 Bench scenario, mid-operation events: reset or clear during EMIT -> mem_we=0 immediately, wr_ptr=0; the next accept writes addr 0.
REQ-037 Bench scenario, with INSTR_ENC_BRANCH_REL_EN: beq, rs=1, rt=2, imm=0 issued at wr_ptr=2 -> 0x1022FFFD.
